// File: rtl/neuron_acc_ctrl.sv
// Sequencer for the combinational perceptron: owns the accumulator,
// streams (activation, weight) pairs, optionally activates, returns result.
module neuron_acc_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_in,
    input  logic             act_cfg,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      in_a,
    input  logic [15:0]      in_w,
    output logic [23:0]      pe_a,
    output logic [15:0]      pe_b,
    output logic [23:0]      pe_x,
    output logic             pe_stop,
    output logic             pe_acti_en,
    input  logic [23:0]      pe_out,
    output logic             busy,
    output logic             res_valid,
    output logic [23:0]      res_data,
    input  logic             res_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ACTIV = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [23:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             act_q, act_d;

    logic in_accum;
    logic in_hs;

    assign in_accum = (state_q == ACCUM);
    assign in_hs    = in_accum & in_valid;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    cnt_d = n_in;
                    act_d = act_cfg;
                    if (n_in != '0)
                        state_d = ACCUM;
                    else if (act_cfg)
                        state_d = ACTIV;
                    else
                        state_d = DONE;
                end
            end
            ACCUM: begin
                if (in_hs) begin
                    acc_d = pe_out;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1))
                        state_d = act_q ? ACTIV : DONE;
                end
            end
            ACTIV: begin
                acc_d   = pe_out;
                state_d = DONE;
            end
            DONE: begin
                if (res_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
        end
    end

    // The perceptron only advances on a real handshake; otherwise it passes x through.
    assign in_ready   = in_accum;
    assign pe_a       = in_accum ? in_a : 24'd0;
    assign pe_b       = in_accum ? in_w : 16'd0;
    assign pe_x       = acc_q;
    assign pe_stop    = ~in_hs;
    assign pe_acti_en = (state_q == ACTIV);
    assign busy       = (state_q != IDLE);
    assign res_valid  = (state_q == DONE);
    assign res_data   = acc_q;

endmodule

// File: doc/neuron_acc_ctrl.md
Name: neuron_acc_ctrl

Overview:
- Sequencing stage directly upstream of the combinational perceptron datapath.
- Owns the 24-bit accumulator register that the perceptron reads as x and writes back through out.
- Streams N (activation, weight) pairs into the perceptron, then optionally applies one activation pass.
- Presents the final 24-bit neuron value on a valid/ready result port.

Parameters:
CNT_W, 8, width of the term counter; max terms per neuron = 2^CNT_W - 1

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
start  in  1  pulse: begin new neuron; sampled only in IDLE
n_in  in  CNT_W  number of terms for this neuron; sampled with start
act_cfg  in  1  1 = apply activation after last term; sampled with start
in_valid  in  1  input pair valid
in_ready  out  1  block accepts pair this cycle
in_a  in  24  activation/input operand
in_w  in  16  weight operand
pe_a  out  24  to perceptron a
pe_b  out  16  to perceptron b
pe_x  out  24  to perceptron x (= accumulator)
pe_stop  out  1  to perceptron stop
pe_acti_en  out  1  to perceptron acti_en
pe_out  in  24  from perceptron out
busy  out  1  state != IDLE
res_valid  out  1  result valid
res_data  out  24  result value
res_ready  in  1  consumer accepts result

Behaviour:
- Registers: state, acc[23:0], cnt[CNT_W-1:0], act_q. All other outputs are combinational from these plus inputs.
- Reset (rst=1 at posedge, any state including mid-operation): state=IDLE, acc=0, cnt=0, act_q=0.
- After reset: in_ready=0, res_valid=0, res_data=0, busy=0, pe_stop=1, pe_acti_en=0, pe_a=0, pe_b=0, pe_x=0.
- Always: pe_x = acc; res_data = acc.
- Outside ACCUM: pe_a=0 and pe_b=0.
- States: IDLE, ACCUM, ACTIV, DONE.
- IDLE:
  - in_ready=0, pe_stop=1, pe_acti_en=0.
  - On start: acc<=0, cnt<=n_in, act_q<=act_cfg.
  - Next state: ACCUM if n_in!=0; else ACTIV if act_cfg; else DONE.
- ACCUM:
  - in_ready=1; pe_a=in_a; pe_b=in_w; pe_acti_en=0.
  - pe_stop = ~in_valid.
  - On handshake (in_valid & in_ready): acc<=pe_out, cnt<=cnt-1.
  - If the handshake occurs with cnt==1: next state ACTIV if act_q, else DONE.
  - No handshake: acc holds (perceptron stopped) and state holds.
- ACTIV (exactly 1 cycle):
  - pe_stop=1, pe_acti_en=1, in_ready=0.
  - acc<=pe_out; next state DONE.
- DONE:
  - res_valid=1, in_ready=0, pe_stop=1.
  - On res_ready: next state IDLE; acc holds until the next start.
  - res_valid and res_data stay stable while res_ready=0.
- Latency:
  - Result valid 1 cycle after the last input handshake without activation; 2 cycles with activation.
  - With n_in=0: valid 1 cycle after start (act_cfg=0) or 2 cycles (act_cfg=1).
- Boundary conditions:
  - start outside IDLE is ignored; n_in and act_cfg changes outside IDLE are ignored.
  - start in the same cycle that DONE handshakes is ignored, because state is not yet IDLE.
  - Accumulation wraps modulo 2^24 inside the perceptron; the block performs no saturation.
  - in_valid in any state other than ACCUM has no effect.

Test Plan:
Bench stub for the perceptron: out = acti_en ? ~x : (stop ? x : x + in_a + {8'b0,b}), all 24-bit.
- Reset, then hold idle -> busy=0, res_valid=0, pe_stop=1, pe_x=0, in_ready=0.
- start with n_in=3, act_cfg=0; pairs (0x10,0x1), (0x20,0x2), (0x30,0x3) issued back-to-back -> res_valid 1 cycle after the 3rd handshake, res_data=0x000066.
- Same stimulus with act_cfg=1 -> pe_acti_en high for exactly 1 cycle; res_valid 2 cycles after the last handshake; res_data=0xFFFF99.
- n_in=2 with in_valid deasserted for 3 cycles between the pairs -> pe_stop=1 and acc constant during the gap; final result correct.
- n_in=0, act_cfg=0 -> res_valid the cycle after start, res_data=0.
- Hold res_ready=0 for 4 cycles in DONE, then assert it -> res_data stable throughout, then IDLE.
- Extra check: a second start pulse during ACCUM is ignored.
- Extra check: rst asserted mid-ACCUM -> next cycle IDLE, pe_x=0.
